// File: rtl/forward_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight register writes behind ID,
// picks the youngest producer per source operand and raises a load-use stall.
module forward_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NSTAGE = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr,
  input  logic [ADDR_W-1:0] id_wa,
  input  logic [2:0]        id_lat,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] wa_q  [NSTAGE];
  logic [2:0]        lat_q [NSTAGE];
  logic [SEL_W-1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              haz_a, haz_b;
  logic              issue, fwd_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Walk oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    sel_a = '0;
    haz_a = 1'b0;
    sel_b = '0;
    haz_b = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (id_use_rs && (id_rs != '0) && vld_q[k] && (wa_q[k] == id_rs)) begin
        haz_a = (lat_q[k] > 3'(k));
        sel_a = haz_a ? '0 : SEL_W'(k + 1);
      end
      if (id_use_rt && (id_rt != '0) && vld_q[k] && (wa_q[k] == id_rt)) begin
        haz_b = (lat_q[k] > 3'(k));
        sel_b = haz_b ? '0 : SEL_W'(k + 1);
      end
    end
  end

  assign stall  = id_valid & ~flush & (haz_a | haz_b);
  assign fwd_ok = id_valid & ~flush & ~stall;
  assign issue  = fwd_ok & id_wr & (id_wa != '0);

  always_comb begin
    vld_d   = {vld_q[NSTAGE-2:0], issue};
    fwd_a_d = fwd_ok ? sel_a : '0;
    fwd_b_d = fwd_ok ? sel_b : '0;
    cnt_d   = stall ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else if (!hold) begin
      vld_q   <= vld_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address/latency fields are qualified by vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!hold) begin
      wa_q[0]  <= id_wa;
      lat_q[0] <= id_lat;
      for (int k = 1; k < NSTAGE; k++) begin
        wa_q[k]  <= wa_q[k-1];
        lat_q[k] <= lat_q[k-1];
      end
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed vector table, saturation loop and
// asynchronous reset sequence, with expected register outputs queued per cycle.
module tb_forward_scoreboard;

  localparam int ADDR_W = 5;
  localparam int NSTAGE = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [ADDR_W-1:0] id_rs = '0, id_rt = '0, id_wa = '0;
  logic              id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0;
  logic [2:0]        id_lat = '0;
  logic              stall;
  logic [SEL_W-1:0]  fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  forward_scoreboard #(
    .ADDR_W(ADDR_W), .NSTAGE(NSTAGE), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr(id_wr), .id_wa(id_wa), .id_lat(id_lat),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && id_valid && id_wr)
      assert (id_lat < 3'(NSTAGE)) else $error("illegal id_lat %0d", id_lat);
  end

  typedef struct {
    logic hold, flush, valid;
    logic use_rs; logic [4:0] rs;
    logic use_rt; logic [4:0] rt;
    logic wr; logic [4:0] wa; logic [2:0] lat;
    logic stall; logic [1:0] fa, fb; logic [3:0] cnt;
  } vec_t;

  typedef struct { logic [1:0] fa, fb; logic [3:0] cnt; } exp_t;

  vec_t tbl[$];
  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic h, f, v, ur, input int rs, input logic ut,
                              input int rt, input logic w, input int wa, input int lat,
                              input logic st, input int fa, fb, cnt);
    vec_t x;
    x.hold = h; x.flush = f; x.valid = v;
    x.use_rs = ur; x.rs = 5'(rs); x.use_rt = ut; x.rt = 5'(rt);
    x.wr = w; x.wa = 5'(wa); x.lat = 3'(lat);
    x.stall = st; x.fa = 2'(fa); x.fb = 2'(fb); x.cnt = 4'(cnt);
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    hold = v.hold; flush = v.flush; id_valid = v.valid;
    id_use_rs = v.use_rs; id_rs = v.rs; id_use_rt = v.use_rt; id_rt = v.rt;
    id_wr = v.wr; id_wa = v.wa; id_lat = v.lat;
    #1;
    chk({tag, " stall"}, int'(stall), int'(v.stall));
    e.fa = v.fa; e.fb = v.fb; e.cnt = v.cnt;
    expq.push_back(e);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    chk({tag, " fwd_a"}, int'(fwd_a), int'(e.fa));
    chk({tag, " fwd_b"}, int'(fwd_b), int'(e.fb));
    chk({tag, " stall_cnt"}, int'(stall_cnt), int'(e.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ecnt;
    // hold flush valid | use_rs rs | use_rt rt | wr wa lat || stall fa fb cnt
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1, 3,0, 0,0,0,0)); // ALU write $3
    tbl.push_back(mk(0,0,1, 1, 3, 0,0, 0, 0,0, 0,1,0,0)); // back-to-back use
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1, 5,1, 0,0,0,0)); // load $5
    tbl.push_back(mk(0,0,1, 0, 0, 1,5, 0, 0,0, 1,0,0,1)); // load-use stall
    tbl.push_back(mk(0,0,1, 0, 0, 1,5, 0, 0,0, 0,0,2,1)); // resolved from MEM
    tbl.push_back(mk(0,0,1, 1, 5, 0,0, 0, 0,0, 0,3,0,1)); // oldest tracked stage
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1, 7,0, 0,0,0,1)); // write $7
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1, 7,0, 0,0,0,1)); // write $7 again
    tbl.push_back(mk(0,0,1, 1, 7, 1,7, 0, 0,0, 0,1,1,1)); // youngest wins, rs==rt
    tbl.push_back(mk(0,0,1, 1, 0, 0,0, 1, 0,0, 0,0,0,1)); // $0 read and write
    tbl.push_back(mk(0,0,1, 1, 0, 1,7, 0, 0,0, 0,0,3,1)); // no $0 entry
    tbl.push_back(mk(1,0,1, 1, 3, 0,0, 1, 9,1, 0,0,3,1)); // hold keeps outputs
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1, 9,1, 0,0,0,1)); // load $9
    tbl.push_back(mk(1,0,1, 1, 9, 0,0, 0, 0,0, 1,0,0,1)); // stall under hold
    tbl.push_back(mk(1,0,1, 1, 9, 0,0, 0, 0,0, 1,0,0,1));
    tbl.push_back(mk(1,0,1, 1, 9, 0,0, 0, 0,0, 1,0,0,1));
    tbl.push_back(mk(0,0,1, 1, 9, 0,0, 0, 0,0, 1,0,0,2)); // frozen board still stalls
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1,11,1, 0,0,0,2)); // load $11
    tbl.push_back(mk(0,1,1, 1,11, 0,0, 0, 0,0, 0,0,0,2)); // flush beats hazard
    tbl.push_back(mk(0,0,1, 1,11, 0,0, 0, 0,0, 0,2,0,2));
    tbl.push_back(mk(0,0,0, 1,11, 0,0, 1,12,0, 0,0,0,2)); // invalid ID
    tbl.push_back(mk(0,0,1, 1,12, 0,0, 0, 0,0, 0,0,0,2)); // no entry from invalid
    tbl.push_back(mk(0,0,1, 0, 0, 0,0, 1,13,2, 0,0,0,2)); // lat 2 producer
    tbl.push_back(mk(0,0,1, 1,13, 0,0, 0, 0,0, 1,0,0,3));
    tbl.push_back(mk(0,0,1, 1,13, 0,0, 0, 0,0, 1,0,0,4));
    tbl.push_back(mk(0,0,1, 1,13, 0,0, 0, 0,0, 0,3,0,4));

    #2 rst_n = 1'b0;
    #6;
    chk("reset fwd_a", int'(fwd_a), 0);
    chk("reset fwd_b", int'(fwd_b), 0);
    chk("reset stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    ecnt = 4;
    for (int i = 0; i < 10; i++) begin
      apply(mk(0,0,1, 1,14, 0,0, 1,14,2, 0,(i == 0) ? 0 : 3,0,ecnt), $sformatf("sat%0d issue", i));
      ecnt = (ecnt == 15) ? 15 : ecnt + 1;
      apply(mk(0,0,1, 1,14, 0,0, 1,14,2, 1,0,0,ecnt), $sformatf("sat%0d st1", i));
      ecnt = (ecnt == 15) ? 15 : ecnt + 1;
      apply(mk(0,0,1, 1,14, 0,0, 1,14,2, 1,0,0,ecnt), $sformatf("sat%0d st2", i));
    end
    apply(mk(0,0,1, 1,14, 0,0, 1,20,1, 0,3,0,15), "pre-reset");

    #2 rst_n = 1'b0;
    #1;
    chk("async reset fwd_a", int'(fwd_a), 0);
    chk("async reset fwd_b", int'(fwd_b), 0);
    chk("async reset stall_cnt", int'(stall_cnt), 0);
    chk("async reset stall", int'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0,0,1, 1,20, 1,20, 0, 0,0, 0,0,0,0), "post-reset read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
